// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - three-slot in-flight write tracker with rs/rt match ports
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] rt_i,
  output logic              rs_match_o,
  output logic              rt_match_o
);

  localparam int NSLOT = 3;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  // Slot 0 is EX, 1 is MEM, 2 is WB; WB drops out when the regfile forwards internally.
  localparam logic [NSLOT-1:0] SLOT_MASK = WB_BYPASS ? 3'b011 : 3'b111;

  logic [NSLOT-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q [NSLOT];
  logic [ADDR_W-1:0] addr_d [NSLOT];

  always_comb begin
    vld_d     = {vld_q[NSLOT-2:0], issue_i};
    addr_d[0] = issue_i ? dst_i : ZERO;
    for (int i = 1; i < NSLOT; i++) begin
      addr_d[i] = addr_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        addr_q[i] <= ZERO;
      end
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    rs_match_o = 1'b0;
    rt_match_o = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (SLOT_MASK[i] && vld_q[i]) begin
        if (addr_q[i] == rs_i) rs_match_o = 1'b1;
        if (addr_q[i] == rt_i) rt_match_o = 1'b1;
      end
    end
    if (rs_i == ZERO) rs_match_o = 1'b0;
    if (rt_i == ZERO) rt_match_o = 1'b0;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW stall / branch flush scheduler for the 5-stage pipeline
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter bit WB_BYPASS   = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic                   ID_Valid,
  input  logic [ADDR_W-1:0]      ID_RSAddr,
  input  logic [ADDR_W-1:0]      ID_RTAddr,
  input  logic                   ID_UsesRS,
  input  logic                   ID_UsesRT,
  input  logic                   ID_RegWriteEN,
  input  logic [ADDR_W-1:0]      ID_DstAddr,
  input  logic                   EX_BranchTaken,
  output logic                   PC_WriteEN,
  output logic                   IFID_WriteEN,
  output logic                   IFID_Flush,
  output logic                   IDEX_Bubble,
  output logic [1:0]             State,
  output logic [STALL_CNT_W-1:0] StallCount
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic rs_match, rt_match, hazard, flush, stall, issue;
  state_e state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  assign hazard = ID_Valid & ((ID_UsesRS & rs_match) | (ID_UsesRT & rt_match));
  assign flush  = EX_BranchTaken;
  assign stall  = hazard & ~flush;
  // A stalled or wrong-path instruction must not claim a scoreboard slot.
  assign issue  = ID_Valid & ID_RegWriteEN & (ID_DstAddr != ZERO) & ~hazard & ~flush;

  hazard_scoreboard #(
    .ADDR_W    (ADDR_W),
    .WB_BYPASS (WB_BYPASS)
  ) u_scoreboard (
    .clk_i      (CLOCK),
    .rst_ni     (RESET_N),
    .issue_i    (issue),
    .dst_i      (ID_DstAddr),
    .rs_i       (ID_RSAddr),
    .rt_i       (ID_RTAddr),
    .rs_match_o (rs_match),
    .rt_match_o (rt_match)
  );

  always_comb begin
    state_d      = ST_RUN;
    PC_WriteEN   = 1'b1;
    IFID_WriteEN = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    if (flush) begin
      state_d     = ST_FLUSH;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (hazard) begin
      state_d      = ST_STALL;
      PC_WriteEN   = 1'b0;
      IFID_WriteEN = 1'b0;
      IDEX_Bubble  = 1'b1;
    end
    if (!RESET_N) begin
      PC_WriteEN   = 1'b0;
      IFID_WriteEN = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Bubble  = 1'b1;
    end
  end

  assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + STALL_CNT_W'(1) : cnt_q;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign State      = state_q;
  assign StallCount = cnt_q;

endmodule
